// File: rtl/ccc_dyncfg_sequencer_if.sv
// ============================================================================
// Module      : ccc_dyncfg_sequencer_if
// Description : Bundles the signals between the CCC dynamic-configuration
//               sequencer and its environment.
//               Requester side: CFG_REQ, CFG_DATA, CFG_ACK, BUSY, DONE,
//               ERR_TIMEOUT.
//               CCC side: PLL_LOCK, LOCKED, SCLK, SDIN, SSHIFT, SUPDATE, and
//               SDOUT/CFG_RDATA when CCC_CFG_READBACK_EN is defined.
//               slave  : sequencer side (drives status and serial outputs)
//               master : environment side (requester plus CCC model)
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ccc_dyncfg_sequencer_if #(
    parameter int CFG_W = 81
);
    logic             CFG_REQ;
    logic [CFG_W-1:0] CFG_DATA;
    logic             CFG_ACK;
    logic             BUSY;
    logic             DONE;
    logic             ERR_TIMEOUT;
    logic             PLL_LOCK;
    logic             LOCKED;
    logic             SCLK;
    logic             SDIN;
    logic             SSHIFT;
    logic             SUPDATE;
`ifdef CCC_CFG_READBACK_EN
    logic             SDOUT;
    logic [CFG_W-1:0] CFG_RDATA;

    modport slave (
        input  CFG_REQ, CFG_DATA, PLL_LOCK, SDOUT,
        output CFG_ACK, BUSY, DONE, ERR_TIMEOUT, LOCKED,
        output SCLK, SDIN, SSHIFT, SUPDATE, CFG_RDATA
    );
    modport master (
        output CFG_REQ, CFG_DATA, PLL_LOCK, SDOUT,
        input  CFG_ACK, BUSY, DONE, ERR_TIMEOUT, LOCKED,
        input  SCLK, SDIN, SSHIFT, SUPDATE, CFG_RDATA
    );
`else
    modport slave (
        input  CFG_REQ, CFG_DATA, PLL_LOCK,
        output CFG_ACK, BUSY, DONE, ERR_TIMEOUT, LOCKED,
        output SCLK, SDIN, SSHIFT, SUPDATE
    );
    modport master (
        output CFG_REQ, CFG_DATA, PLL_LOCK,
        input  CFG_ACK, BUSY, DONE, ERR_TIMEOUT, LOCKED,
        input  SCLK, SDIN, SSHIFT, SUPDATE
    );
`endif
endinterface

`default_nettype wire

// File: rtl/ccc_dyncfg_sequencer.sv
// ============================================================================
// Module      : ccc_dyncfg_sequencer
// Description : Reconfigures the MSS CCC/PLL through its dynamic serial port.
//               Captures a parallel config word, shifts it out LSB-first on
//               SCLK/SDIN with SSHIFT high, strobes SUPDATE, then waits for a
//               filtered PLL lock or a timeout.
// Ports       : FAB_CLK   - sole clock
//               FAB_RESET - synchronous active-high reset
//               bus       - ccc_dyncfg_sequencer_if.slave (request handshake,
//                           status, CCC serial port, PLL lock)
// Options     : CCC_CFG_READBACK_EN - samples SDOUT on each SCLK rise during
//               the shift and presents the old CCC word on CFG_RDATA.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ccc_dyncfg_sequencer #(
    parameter int CFG_W        = 81,
    parameter int SCLK_DIV     = 4,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  wire logic             FAB_CLK,
    input  wire logic             FAB_RESET,
    ccc_dyncfg_sequencer_if.slave bus
);

    localparam int c_div_w = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int c_bit_w = (CFG_W > 1) ? $clog2(CFG_W) : 1;
    localparam int c_stb_w = $clog2(LOCK_STABLE + 1);
    localparam int c_tmo_w = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCLK_DIV - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(CFG_W - 1);
    localparam logic [c_stb_w-1:0] c_stb_max  = c_stb_w'(LOCK_STABLE);
    localparam logic [c_tmo_w-1:0] c_tmo_max  = c_tmo_w'(LOCK_TIMEOUT);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_shift  = 2'd1;
    localparam logic [1:0] c_st_update = 2'd2;
    localparam logic [1:0] c_st_wait   = 2'd3;

    logic [1:0]         state_q,  state_d;
    logic [CFG_W-1:0]   shadow_q, shadow_d;   // bits not yet placed on SDIN
    logic [c_div_w-1:0] div_q,    div_d;
    logic [c_bit_w-1:0] bit_q,    bit_d;
    logic [c_stb_w-1:0] stb_q,    stb_d;
    logic [c_tmo_w-1:0] tmo_q,    tmo_d;
    logic               sync1_q,  sync1_d;
    logic               sync2_q,  sync2_d;
    logic               ack_q,    ack_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic               err_q,    err_d;
    logic               locked_q, locked_d;
    logic               sclk_q,   sclk_d;
    logic               sdin_q,   sdin_d;
    logic               sshift_q, sshift_d;
    logic               supd_q,   supd_d;
`ifdef CCC_CFG_READBACK_EN
    logic [CFG_W-1:0]   rdata_q,  rdata_d;
`endif

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        div_d    = div_q;
        bit_d    = bit_q;
        stb_d    = stb_q;
        tmo_d    = tmo_q;
        ack_d    = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;
        err_d    = err_q;
        locked_d = locked_q;
        sclk_d   = sclk_q;
        sdin_d   = sdin_q;
        sshift_d = sshift_q;
        supd_d   = supd_q;
        sync1_d  = bus.PLL_LOCK;
        sync2_d  = sync1_q;
`ifdef CCC_CFG_READBACK_EN
        rdata_d  = rdata_q;
`endif

        // Lock filter: saturating run-length of synced-high cycles. Any low
        // cycle restarts the run and drops LOCKED on the next edge.
        if (!sync2_q) begin
            stb_d = '0;
        end else if (stb_q != c_stb_max) begin
            stb_d = stb_q + 1'b1;
        end
        if (!sync2_q) begin
            locked_d = 1'b0;
        end else if (stb_d == c_stb_max) begin
            locked_d = 1'b1;
        end

        // BUSY stays up through the DONE cycle and falls one cycle later,
        // unless a still-pending request is captured in that same cycle.
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            c_st_idle: begin
                if (bus.CFG_REQ) begin
                    // SDIN is loaded with bit 0 right away; the shadow holds
                    // the remaining bits so the next one is always at [0].
                    shadow_d = bus.CFG_DATA >> 1;
                    sdin_d   = bus.CFG_DATA[0];
                    ack_d    = 1'b1;
                    busy_d   = 1'b1;
                    err_d    = 1'b0;
                    sshift_d = 1'b1;
                    sclk_d   = 1'b0;
                    div_d    = '0;
                    bit_d    = '0;
                    state_d  = c_st_shift;
                end
            end

            c_st_shift: begin
                if (div_q == c_div_last) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
`ifdef CCC_CFG_READBACK_EN
                        rdata_d = {bus.SDOUT, rdata_q[CFG_W-1:1]};
`endif
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == c_bit_last) begin
                            sshift_d = 1'b0;
                            sdin_d   = 1'b0;
                            supd_d   = 1'b1;
                            locked_d = 1'b0;
                            stb_d    = '0;
                            state_d  = c_st_update;
                        end else begin
                            bit_d    = bit_q + 1'b1;
                            sdin_d   = shadow_q[0];
                            shadow_d = shadow_q >> 1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            c_st_update: begin
                // Lock observed before the update belongs to the old
                // configuration, so the synchroniser is flushed and the new
                // lock has to propagate through both stages again.
                sync1_d  = 1'b0;
                sync2_d  = 1'b0;
                stb_d    = '0;
                locked_d = 1'b0;
                if (div_q == c_div_last) begin
                    div_d   = '0;
                    supd_d  = 1'b0;
                    tmo_d   = '0;
                    state_d = c_st_wait;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            c_st_wait: begin
                if (tmo_q != c_tmo_max) begin
                    tmo_d = tmo_q + 1'b1;
                end
                // Success is checked first so it wins a same-cycle tie.
                if (stb_d == c_stb_max) begin
                    done_d   = 1'b1;
                    locked_d = 1'b1;
                    state_d  = c_st_idle;
                end else if (tmo_d == c_tmo_max) begin
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    locked_d = 1'b0;
                    state_d  = c_st_idle;
                end
            end

            default: state_d = c_st_idle;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (FAB_RESET) begin
            state_q  <= c_st_idle;
            shadow_q <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            stb_q    <= '0;
            tmo_q    <= '0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            sclk_q   <= 1'b0;
            sdin_q   <= 1'b0;
            sshift_q <= 1'b0;
            supd_q   <= 1'b0;
`ifdef CCC_CFG_READBACK_EN
            rdata_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            stb_q    <= stb_d;
            tmo_q    <= tmo_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            sclk_q   <= sclk_d;
            sdin_q   <= sdin_d;
            sshift_q <= sshift_d;
            supd_q   <= supd_d;
`ifdef CCC_CFG_READBACK_EN
            rdata_q  <= rdata_d;
`endif
        end
    end

    assign bus.CFG_ACK     = ack_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.ERR_TIMEOUT = err_q;
    assign bus.LOCKED      = locked_q;
    assign bus.SCLK        = sclk_q;
    assign bus.SDIN        = sdin_q;
    assign bus.SSHIFT      = sshift_q;
    assign bus.SUPDATE     = supd_q;
`ifdef CCC_CFG_READBACK_EN
    assign bus.CFG_RDATA   = rdata_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ccc_dyncfg_sequencer.sv
// ============================================================================
// Module      : tb_ccc_dyncfg_sequencer
// Description : Self-checking bench for ccc_dyncfg_sequencer (CFG_W=8,
//               SCLK_DIV=2, LOCK_STABLE=16, LOCK_TIMEOUT=100). A vector table
//               drives whole sequences; expected results are queued when a
//               request is driven and compared when DONE appears. Hand-written
//               sequences cover reset, idle lock filtering and reset mid-shift.
//               CCC_CFG_READBACK_EN adds CFG_RDATA checks.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ccc_dyncfg_sequencer;

    localparam int CFG_W        = 8;
    localparam int SCLK_DIV     = 2;
    localparam int LOCK_STABLE  = 16;
    localparam int LOCK_TIMEOUT = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ccc_dyncfg_sequencer_if #(.CFG_W(CFG_W)) bus ();

    ccc_dyncfg_sequencer #(
        .CFG_W       (CFG_W),
        .SCLK_DIV    (SCLK_DIV),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) u_dut (
        .FAB_CLK  (clk),
        .FAB_RESET(rst),
        .bus      (bus)
    );

    // lock_mode: 0 = lock high throughout, 1 = lock low throughout,
    //            2 = one-cycle glitch low at stable count 10
    typedef struct {
        logic [7:0] data;
        int         lock_mode;
        bit         hold_req;
        int         exp_off;     // DONE cycle counted from first SUPDATE-low cycle
        bit         exp_err;
        bit         exp_locked;
        logic [7:0] sdout_pat;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        int         exp_off;
        bit         exp_err;
        bit         exp_locked;
        bit         hold_req;
        logic [7:0] sdout_pat;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[5];

    int total = 0;
    int bad   = 0;

    // monitor state
    bit         prev_sclk = 0, prev_supd = 0, in_txn = 0, wait_active = 0;
    bit         busy_chk_pending = 0, ack_chk_pending = 0;
    int         sshift_cnt = 0, supd_cnt = 0, supd_pulses = 0, rise_cnt = 0;
    int         wait_cnt = 0, stray_ack = 0, done_cnt = 0, cur_lock_mode = 0;
    logic [7:0] bits_seen = '0;

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic finish_txn();
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty_at_done", sb_q.size(), 1);
        end else begin
            e = sb_q.pop_front();
            chk("sdin_bits",       bits_seen,       e.data);
            chk("sclk_rises",      rise_cnt,        CFG_W);
            chk("sshift_cycles",   sshift_cnt,      CFG_W * 2 * SCLK_DIV);
            chk("supdate_cycles",  supd_cnt,        SCLK_DIV);
            chk("supdate_pulses",  supd_pulses,     1);
            chk("done_offset",     wait_cnt,        e.exp_off);
            chk("err_at_done",     bus.ERR_TIMEOUT, e.exp_err);
            chk("locked_at_done",  bus.LOCKED,      e.exp_locked);
            chk("busy_at_done",    bus.BUSY,        1);
            chk("ack_while_busy",  stray_ack,       0);
            if (e.hold_req) ack_chk_pending = 1;
            else            busy_chk_pending = 1;
        end
        in_txn      = 0;
        wait_active = 0;
        done_cnt++;
    endtask

    // One clock: sample at the falling edge, run the monitor, then drive
    // the CCC-side inputs for the next rising edge.
    task automatic step();
        @(negedge clk);
        if (busy_chk_pending) begin
            chk("busy_after_done", bus.BUSY, 0);
            busy_chk_pending = 0;
        end
        if (ack_chk_pending) begin
            chk("reack_after_done", bus.CFG_ACK, 1);
            ack_chk_pending = 0;
        end
        if (rst) begin
            in_txn      = 0;
            wait_active = 0;
        end else begin
            if (bus.CFG_ACK) begin
                if (in_txn) begin
                    stray_ack++;
                end else begin
                    in_txn      = 1;
                    sshift_cnt  = 0;
                    supd_cnt    = 0;
                    supd_pulses = 0;
                    rise_cnt    = 0;
                    wait_cnt    = 0;
                    stray_ack   = 0;
                    bits_seen   = '0;
                    chk("err_clear_on_ack", bus.ERR_TIMEOUT, 0);
                end
            end
            if (in_txn) begin
                if (bus.SSHIFT) sshift_cnt++;
                if (bus.SCLK && !prev_sclk) begin
                    if (rise_cnt < CFG_W) bits_seen[rise_cnt] = bus.SDIN;
                    rise_cnt++;
                end
                if (bus.SUPDATE) begin
                    supd_cnt++;
                    if (!prev_supd) begin
                        supd_pulses++;
`ifdef CCC_CFG_READBACK_EN
                        if (sb_q.size() > 0) chk("cfg_rdata", bus.CFG_RDATA, sb_q[0].sdout_pat);
`endif
                    end
                end
                if (prev_supd && !bus.SUPDATE) begin
                    wait_active = 1;
                    wait_cnt    = 0;
                end else if (wait_active) begin
                    wait_cnt++;
                end
                if (bus.DONE) finish_txn();
            end else begin
                if (bus.SUPDATE) chk("supdate_outside_txn", bus.SUPDATE, 0);
                if (bus.DONE)    chk("done_outside_txn", bus.DONE, 0);
            end
        end
        prev_sclk = bus.SCLK;
        prev_supd = bus.SUPDATE;
`ifdef CCC_CFG_READBACK_EN
        if (in_txn && rise_cnt < CFG_W && sb_q.size() > 0) bus.SDOUT = sb_q[0].sdout_pat[rise_cnt];
        else                                               bus.SDOUT = 1'b0;
`endif
        if (cur_lock_mode == 2 && wait_active) begin
            if (wait_cnt == 10)      bus.PLL_LOCK = 1'b0;
            else if (wait_cnt == 11) bus.PLL_LOCK = 1'b1;
        end
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   target;
        int   start;
        e.data       = v.data;
        e.exp_off    = v.exp_off;
        e.exp_err    = v.exp_err;
        e.exp_locked = v.exp_locked;
        e.hold_req   = v.hold_req;
        e.sdout_pat  = v.sdout_pat;
        sb_q.push_back(e);
        if (v.hold_req) begin
            e.hold_req = 0;
            sb_q.push_back(e);
        end
        start         = done_cnt;
        target        = done_cnt + (v.hold_req ? 2 : 1);
        cur_lock_mode = v.lock_mode;
        bus.PLL_LOCK  = (v.lock_mode == 1) ? 1'b0 : 1'b1;
        bus.CFG_DATA  = v.data;
        bus.CFG_REQ   = 1'b1;
        for (int c = 0; c < 1000 && done_cnt < target; c++) begin
            step();
            if (bus.CFG_ACK && (!v.hold_req || done_cnt > start)) bus.CFG_REQ = 1'b0;
        end
        if (done_cnt < target) begin
            chk("txn_timeout_done_count", done_cnt, target);
            sb_q.delete();
            in_txn = 0;
        end
        bus.CFG_REQ   = 1'b0;
        cur_lock_mode = 0;
        repeat (3) step();
    endtask

    initial begin
        int supd_seen;
        bit reached;
        rst          = 1'b1;
        bus.CFG_REQ  = 1'b0;
        bus.CFG_DATA = '0;
        bus.PLL_LOCK = 1'b0;
`ifdef CCC_CFG_READBACK_EN
        bus.SDOUT    = 1'b0;
`endif
        vecs[0] = '{data: 8'hA5, lock_mode: 0, hold_req: 0, exp_off: 18,  exp_err: 0, exp_locked: 1, sdout_pat: 8'h3C};
        vecs[1] = '{data: 8'h5A, lock_mode: 0, hold_req: 0, exp_off: 18,  exp_err: 0, exp_locked: 1, sdout_pat: 8'hC3};
        vecs[2] = '{data: 8'hFF, lock_mode: 1, hold_req: 0, exp_off: 100, exp_err: 1, exp_locked: 0, sdout_pat: 8'h81};
        vecs[3] = '{data: 8'h01, lock_mode: 2, hold_req: 0, exp_off: 29,  exp_err: 0, exp_locked: 1, sdout_pat: 8'h7E};
        vecs[4] = '{data: 8'h80, lock_mode: 0, hold_req: 1, exp_off: 18,  exp_err: 0, exp_locked: 1, sdout_pat: 8'h55};

        // reset state
        repeat (4) step();
        chk("rst_ack",     bus.CFG_ACK,     0);
        chk("rst_busy",    bus.BUSY,        0);
        chk("rst_done",    bus.DONE,        0);
        chk("rst_err",     bus.ERR_TIMEOUT, 0);
        chk("rst_locked",  bus.LOCKED,      0);
        chk("rst_sclk",    bus.SCLK,        0);
        chk("rst_sdin",    bus.SDIN,        0);
        chk("rst_sshift",  bus.SSHIFT,      0);
        chk("rst_supdate", bus.SUPDATE,     0);
`ifdef CCC_CFG_READBACK_EN
        chk("rst_rdata",   bus.CFG_RDATA,   0);
`endif
        rst = 1'b0;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // idle lock monitoring: one low cycle on PLL_LOCK while LOCKED=1
        bus.PLL_LOCK = 1'b1;
        step();
        chk("idle_locked_before", bus.LOCKED, 1);
        bus.PLL_LOCK = 1'b0;            // low at edge ending cycle N
        step();                         // N+1
        bus.PLL_LOCK = 1'b1;
        step();                         // N+2
        chk("idle_locked_n2", bus.LOCKED, 1);
        step();                         // N+3
        chk("idle_locked_fall", bus.LOCKED, 0);
        repeat (15) step();             // N+18
        chk("idle_locked_n18", bus.LOCKED, 0);
        step();                         // N+19
        chk("idle_locked_rise", bus.LOCKED, 1);

        // reset during bit 3 of the shift
        bus.CFG_DATA = 8'hA5;
        bus.CFG_REQ  = 1'b1;
        reached      = 0;
        for (int c = 0; c < 200 && !reached; c++) begin
            step();
            if (bus.CFG_ACK) bus.CFG_REQ = 1'b0;
            if (in_txn && rise_cnt == 4) reached = 1;
        end
        chk("reached_bit3", reached, 1);
        rst = 1'b1;
        step();
        chk("midrst_sclk",    bus.SCLK,    0);
        chk("midrst_sshift",  bus.SSHIFT,  0);
        chk("midrst_supdate", bus.SUPDATE, 0);
        chk("midrst_busy",    bus.BUSY,    0);
        rst = 1'b0;
        supd_seen = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (bus.SUPDATE) supd_seen++;
        end
        chk("midrst_no_supdate", supd_seen, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
